uart_rx_fifo: RTL

//  Receive-side byte buffer directly downstream of the UART receiver.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_fifo_if.sv | 38 +++
 rtl/uart_fifo_mem.sv | 31 +++
 rtl/uart_rx_fifo.sv | 91 +++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART byte width and byte type for receiver, transmitter
//            and receive FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_if
// Brief    : Byte capture, show-ahead read port and status of the RX FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
);
  import uart_pkg::*;

  localparam int LW = $clog2(DEPTH) + 1;

  logic          rx_done;
  uart_byte_t    rx_data;
  logic          m_valid;
  logic          m_ready;
  uart_byte_t    m_data;
  logic [LW-1:0] level;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic          overrun;
  logic          overrun_clr;

  // master: the FIFO itself; slave: receiver/host side driving it
  modport master (
    input  rx_done, rx_data, m_ready, overrun_clr,
    output m_valid, m_data, level, empty, full, almost_full, overrun
  );

  modport slave (
    output rx_done, rx_data, m_ready, overrun_clr,
    input  m_valid, m_data, level, empty, full, almost_full, overrun
  );

endinterface
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_mem
// Brief    : DEPTH x byte storage, one synchronous write port, async read.
// Revision : 1.0 - initial release
// ============================================================================
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  uart_byte_t               wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output uart_byte_t               rdata
);

  uart_byte_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Show-ahead receive FIFO behind the UART receiver with sticky
//            overrun flag and registered occupancy/status outputs.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 12
) (
  input  logic           clk,
  input  logic           rstn,
  uart_rx_fifo_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] C_ONE   = PW'(1);
  localparam logic [PW-1:0] C_AFULL = PW'(AFULL_LVL);

  logic [PW-1:0] r_wr_ptr, r_rd_ptr, r_level;
  logic [PW-1:0] w_wr_nxt, w_rd_nxt, w_level_nxt;
  logic          r_empty, r_full, r_afull, r_overrun;
  logic          w_push, w_pop, w_drop;

  assign w_pop  = ~r_empty & bus.m_ready;
  assign w_push = bus.rx_done & (~r_full | w_pop);
  assign w_drop = bus.rx_done & r_full & ~w_pop;

  always_comb begin
    w_wr_nxt    = r_wr_ptr;
    w_rd_nxt    = r_rd_ptr;
    w_level_nxt = r_level;
    if (w_push) w_wr_nxt = r_wr_ptr + C_ONE;
    if (w_pop)  w_rd_nxt = r_rd_ptr + C_ONE;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + C_ONE;
      2'b01:   w_level_nxt = r_level - C_ONE;
      default: w_level_nxt = r_level;
    endcase
  end

  // Flags are derived from next-state pointers so they change on the same edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_afull   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_wr_ptr  <= w_wr_nxt;
      r_rd_ptr  <= w_rd_nxt;
      r_level   <= w_level_nxt;
      r_empty   <= (w_wr_nxt == w_rd_nxt);
      r_full    <= (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]) &&
                   (w_wr_nxt[AW] != w_rd_nxt[AW]);
      r_afull   <= (w_level_nxt >= C_AFULL);
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (bus.overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wr_ptr[AW-1:0]),
    .wdata (bus.rx_data),
    .raddr (r_rd_ptr[AW-1:0]),
    .rdata (bus.m_data)
  );

  assign bus.m_valid     = ~r_empty;
  assign bus.level       = r_level;
  assign bus.empty       = r_empty;
  assign bus.full        = r_full;
  assign bus.almost_full = r_afull;
  assign bus.overrun     = r_overrun;

endmodule
`default_nettype wire
